// File: rtl/async_rr_arbiter_pkg.sv
// async_rr_arbiter_pkg: shared definitions for the round-robin arbiter.
//   arb_state_t : FSM state encoding (FETCH, DRAIN, HOLD)
//   clog2       : index width helper, never returns less than 1
package async_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/async_rr_arbiter_pointer.sv
// rr_pointer: round-robin source pointer with wrap-around increment.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, pointer returns to 0
//   advance : step to the next source on this edge
//   ptr     : current source index
module rr_pointer
  import async_rr_arbiter_pkg::*;
#(
  parameter int input_size = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  output logic [clog2(input_size)-1:0] ptr
);

  localparam int ID_W = clog2(input_size);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == ID_W'(input_size - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/async_rr_arbiter.sv
// async_rr_arbiter: collects one word at a time from input_size upstream
// sources in round-robin order and hands it to a single downstream consumer.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req_l   : per-source request (at most one bit high)
//   ack_l   : per-source one-cycle ack, data valid in the same cycle
//   din     : packed source data, source i at [data_width*(i+1)-1 : data_width*i]
//   req_r   : downstream request
//   ack_r   : one-cycle ack to downstream while dout is valid
//   dout    : buffered word
//   dout_id : source index that supplied dout
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FETCH | requesting source ptr, counting cycles toward the skip limit
// ST_DRAIN | one cycle after a skip; a late ack from ptr is still taken
// ST_HOLD  | word buffered, waiting to hand it downstream
module async_rr_arbiter
  import async_rr_arbiter_pkg::*;
#(
  parameter int data_width = 32,
  parameter int input_size = 4,
  parameter int wait_limit = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [input_size-1:0]            req_l,
  input  logic [input_size-1:0]            ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic                             req_r,
  output logic                             ack_r,
  output logic [data_width-1:0]            dout,
  output logic [clog2(input_size)-1:0]     dout_id
);

  localparam int ID_W  = clog2(input_size);
  localparam int CNT_W = clog2(wait_limit + 2);
  localparam logic [input_size-1:0] REQ_ONE = input_size'(1);

  arb_state_t            state;
  logic [ID_W-1:0]       ptr;
  logic [CNT_W-1:0]      wait_cnt;
  logic [data_width-1:0] din_sel;
  logic                  ack_hit;
  logic                  timeout;
  logic                  ptr_adv;

  rr_pointer #(.input_size(input_size)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (ptr_adv),
    .ptr     (ptr)
  );

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < input_size; i++) begin
      if (ptr == ID_W'(i)) din_sel = din[i*data_width +: data_width];
    end
  end

  assign ack_hit = ack_l[ptr];

  // Fires on the last of wait_limit FETCH cycles; disabled when wait_limit is 0.
  assign timeout = (wait_limit > 0) && (wait_cnt == CNT_W'(wait_limit - 1));

  // The pointer moves on a skip without a late ack, or once the buffered word
  // has been handed off (ptr still equals dout_id throughout HOLD).
  assign ptr_adv = ((state == ST_DRAIN) && !ack_hit) ||
                   ((state == ST_HOLD) && ack_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      req_l    <= '0;
      ack_r    <= 1'b0;
      dout     <= '0;
      dout_id  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // A capture wins over a timeout landing on the same edge.
          if (ack_hit) begin
            dout     <= din_sel;
            dout_id  <= ptr;
            req_l    <= '0;
            wait_cnt <= '0;
            state    <= ST_HOLD;
          end else if (timeout) begin
            req_l    <= '0;
            wait_cnt <= '0;
            state    <= ST_DRAIN;
          end else begin
            req_l    <= REQ_ONE << ptr;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ack_hit) begin
            dout    <= din_sel;
            dout_id <= ptr;
            state   <= ST_HOLD;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (ack_r) begin
            ack_r <= 1'b0;
            state <= ST_FETCH;
          end else if (req_r) begin
            ack_r <= 1'b1;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_async_rr_arbiter.sv
// tb_async_rr_arbiter: directed phases plus a randomized run against a
// source/consumer model and a round-robin word-order scoreboard.
module tb_async_rr_arbiter;

  localparam int DW    = 32;
  localparam int N     = 4;
  localparam int WL    = 8;
  localparam int NEVER = -1;
  localparam int RAND  = -2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_l;
  logic [N-1:0]    ack_l;
  logic [DW*N-1:0] din;
  logic            req_r;
  logic            ack_r;
  logic [DW-1:0]   dout;
  logic [1:0]      dout_id;

  async_rr_arbiter #(.data_width(DW), .input_size(N), .wait_limit(WL)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_l   (req_l),
    .ack_l   (ack_l),
    .din     (din),
    .req_r   (req_r),
    .ack_r   (ack_r),
    .dout    (dout),
    .dout_id (dout_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // source models: next value, delay config, per-request delay, arm cycle
  int val [N];
  int exp_val [N];
  int cfg [N];
  int dly [N];
  int seen [N];
  bit armed [N];

  // scoreboard for the buffered word
  bit            pend;
  int            exp_id;
  logic [DW-1:0] exp_dout;
  int            cap_extra;
  int            last_id;
  int            last_ackr_cyc;
  bit            gap_en;
  bit            spur_en;
  int            ackr_model;
  int            ackr_dut;
  int            hon_cnt;

  bit fire;
  int fire_src;
  int fire_dly;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // next source in round-robin order that will ever answer
  function automatic int pred_next();
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last_id + k) % N;
      if (cfg[j] != NEVER) return j;
    end
    return 0;
  endfunction

  task automatic drive_sources();
    int j;
    fire = 1'b0;
    fire_src = 0;
    fire_dly = 0;
    ack_l = '0;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        armed[i] = 1'b0;
      end else begin
        if (!armed[i] && req_l[i] === 1'b1 && cfg[i] != NEVER) begin
          armed[i] = 1'b1;
          seen[i] = cyc;
          dly[i] = (cfg[i] == RAND) ? int'($urandom_range(0, 3)) : cfg[i];
        end
        if (armed[i] && cyc == seen[i] + dly[i]) begin
          ack_l[i] = 1'b1;
          din[i*DW +: DW] = val[i];
          val[i]++;
          armed[i] = 1'b0;
          fire = 1'b1;
          fire_src = i;
          fire_dly = dly[i];
        end
      end
    end
    // stray ack on a source that is not the one being served
    if (!rst && spur_en && (pend || (|req_l)) && $urandom_range(0, 3) == 0) begin
      j = int'($urandom_range(0, N - 1));
      if (!armed[j] && req_l[j] !== 1'b1 && !(fire && fire_src == j)) ack_l[j] = 1'b1;
    end
  endtask

  task automatic tick();
    bit cur_rst;
    bit cur_rr;
    bit cur_fire;
    int cur_dly;
    bit exp_ackr;
    int nxt;
    drive_sources();
    cur_rst = rst;
    cur_rr = req_r;
    cur_fire = fire;
    cur_dly = fire_dly;
    @(posedge clk);
    #1;
    cyc++;
    chk("req_onehot", 64'($countones(req_l) <= 1), 64'd1);
    chk("req_ackr_excl", 64'((|req_l) && ack_r), 64'd0);
    if (ack_r === 1'b1) ackr_dut++;
    if (cur_rst) begin
      chk("rst_req_l", 64'(req_l), 64'd0);
      chk("rst_ack_r", 64'(ack_r), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_dout_id", 64'(dout_id), 64'd0);
      pend = 1'b0;
      last_id = N - 1;
      last_ackr_cyc = -1;
    end else begin
      exp_ackr = pend && cur_rr;
      chk("ack_r", 64'(ack_r), 64'(exp_ackr));
      if (pend) begin
        chk("hold_dout", 64'(dout), 64'(exp_dout));
        chk("hold_id", 64'(dout_id), 64'(exp_id));
      end
      if (exp_ackr) begin
        ackr_model++;
        pend = 1'b0;
        if (gap_en && last_ackr_cyc >= 0)
          chk("ackr_gap", 64'(cyc - last_ackr_cyc), 64'(4 + cap_extra));
        last_ackr_cyc = cyc;
        last_id = exp_id;
      end
      if (cur_fire) begin
        nxt = pred_next();
        chk("cap_id", 64'(dout_id), 64'(nxt));
        chk("cap_dout", 64'(dout), 64'(exp_val[nxt]));
        exp_dout = exp_val[nxt];
        exp_id = nxt;
        exp_val[nxt]++;
        hon_cnt++;
        cap_extra = cur_dly + ((nxt - last_id - 1 + N) % N) * (WL + 1);
        pend = 1'b1;
      end
    end
  endtask

  task automatic start_phase(input int b0, input int b1, input int b2, input int b3,
                             input int c0, input int c1, input int c2, input int c3);
    rst = 1'b1;
    val[0] = b0; val[1] = b1; val[2] = b2; val[3] = b3;
    cfg[0] = c0; cfg[1] = c1; cfg[2] = c2; cfg[3] = c3;
    for (int i = 0; i < N; i++) exp_val[i] = val[i];
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_words(input int n, input int budget, input bit rand_rr);
    int target;
    int limit;
    target = ackr_model + n;
    limit = cyc + budget;
    while (ackr_model < target && cyc < limit) begin
      if (rand_rr) req_r = 1'($urandom_range(0, 1));
      tick();
    end
    chk("run_budget", 64'(ackr_model >= target), 64'd1);
  endtask

  initial begin
    int lim;
    rst = 1'b1;
    req_r = 1'b0;
    ack_l = '0;
    din = '0;
    spur_en = 1'b0;
    gap_en = 1'b0;
    pend = 1'b0;
    last_id = N - 1;
    last_ackr_cyc = -1;
    ackr_model = 0;
    ackr_dut = 0;
    hon_cnt = 0;
    cap_extra = 0;
    exp_id = 0;
    exp_dout = '0;
    for (int i = 0; i < N; i++) begin
      cfg[i] = 0; val[i] = 0; exp_val[i] = 0; armed[i] = 1'b0; dly[i] = 0; seen[i] = 0;
    end
    tick();
    tick();

    // plain rotation, immediate acks, back-to-back downstream
    spur_en = 1'b1;
    gap_en = 1'b1;
    req_r = 1'b1;
    start_phase(0, 100, 200, 300, 0, 0, 0, 0);
    run_words(12, 300, 1'b0);

    // source 2 silent: skipped after the full wait plus drain
    start_phase(1000, 1100, 1200, 1300, 0, 0, NEVER, 0);
    run_words(9, 500, 1'b0);

    // source 1 answers in the drain cycle, source 3 on the timeout edge
    start_phase(0, 55, 20, 30, 0, 7, 0, 6);
    run_words(8, 500, 1'b0);

    // reset while a word is held
    gap_en = 1'b0;
    req_r = 1'b0;
    start_phase(7, 10, 20, 30, 0, 0, 0, 0);
    lim = cyc + 20;
    while (!pend && cyc < lim) tick();
    chk("d_captured", 64'(pend), 64'd1);
    repeat (3) tick();
    chk("d_dout_seven", 64'(dout), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("d_restart_req", 64'(req_l), 64'b0001);
    req_r = 1'b1;
    run_words(1, 50, 1'b0);

    // random source latency and downstream stalls
    start_phase(int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)),
                int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)),
                RAND, RAND, RAND, RAND);
    ackr_dut = 0;
    hon_cnt = 0;
    run_words(5000, 70000, 1'b1);
    chk("pulse_balance", 64'(ackr_dut + int'(pend)), 64'(hon_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
